// File: rtl/weight_buffer_pp.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | weight_buffer_pp : ping-pong kernel weight buffer with valid/ready output;  |
// | optional collision checker enabled by WB_COLLISION_CHK_EN. Rev 1.0          |
// +-----------------------------------------------------------------------------+
module weight_buffer_pp #(
    parameter int LANES    = 256,
    parameter int KTAPS    = 9,
    parameter int ADDR_LEN = 10,
    parameter int WR_LEN   = 256,
    parameter int RD_LAT   = 2,
    localparam int ROW_W   = LANES * 8,
    localparam int SEL_W   = (ROW_W / WR_LEN > 1) ? $clog2(ROW_W / WR_LEN) : 1,
    localparam int KER_W   = ROW_W * KTAPS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic                wr_bank,
    input  logic [ADDR_LEN-1:0] wr_addr,
    input  logic [SEL_W-1:0]    wr_sel,
    input  logic [WR_LEN-1:0]   wr_data,
    input  logic                rd_start,
    input  logic                rd_bank,
    input  logic [ADDR_LEN-1:0] rd_base,
    output logic [KER_W-1:0]    ker_out,
    output logic                ker_valid,
    input  logic                ker_ready,
    output logic                idle,
    output logic                err_collision
);

    localparam int DEPTH = 2 ** ADDR_LEN;
    localparam int CNT_W = $clog2(KTAPS + 1);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(KTAPS - 1);
    localparam logic [CNT_W-1:0] NUM_TAPS = CNT_W'(KTAPS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                bank_q, bank_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]    issue_q, issue_d;
    logic [CNT_W-1:0]    cap_q, cap_d;
    logic [KER_W-1:0]    ker_q, ker_d;
    logic                valid_q, valid_d;
    logic [RD_LAT-1:0]   vld_q;
    logic [ROW_W-1:0]    stage_q [KTAPS];
    logic [ROW_W-1:0]    mem_q   [2*DEPTH];
    logic [ROW_W-1:0]    rdp_q   [RD_LAT];

    logic                w_rd_en;
    logic                w_capture;
    logic                w_accept;
    logic [KER_W-1:0]    w_ker;

    assign w_rd_en   = (state_q == S_FETCH);
    assign w_capture = vld_q[RD_LAT-1];
    assign w_accept  = rd_start && ((state_q == S_IDLE) || ((state_q == S_HOLD) && ker_ready));

    // Storage is never reset; the read sees pre-write data (read-first).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_bank, wr_addr}][wr_sel*WR_LEN +: WR_LEN] <= wr_data;
        end
        if (w_rd_en) begin
            rdp_q[0] <= mem_q[{bank_q, addr_q}];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            rdp_q[i] <= rdp_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bank_q  <= 1'b0;
            addr_q  <= '0;
            issue_q <= '0;
            cap_q   <= '0;
            ker_q   <= '0;
            valid_q <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < KTAPS; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            bank_q   <= bank_d;
            addr_q   <= addr_d;
            issue_q  <= issue_d;
            cap_q    <= cap_d;
            ker_q    <= ker_d;
            valid_q  <= valid_d;
            vld_q[0] <= w_rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            // Oldest tap drifts down to index 0 as later taps arrive.
            if (w_capture) begin
                for (int i = 0; i < KTAPS - 1; i++) begin
                    stage_q[i] <= stage_q[i+1];
                end
                stage_q[KTAPS-1] <= rdp_q[RD_LAT-1];
            end
        end
    end

    always_comb begin
        w_ker = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < KTAPS; k++) begin
                w_ker[(l*KTAPS + k)*8 +: 8] = stage_q[k][l*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        issue_d = issue_q;
        cap_d   = w_capture ? cap_q + 1'b1 : cap_q;
        ker_d   = ker_q;
        valid_d = valid_q;
        case (state_q)
            S_FETCH: begin
                addr_d  = addr_q + 1'b1;
                issue_d = issue_q + 1'b1;
                if (issue_q == LAST_TAP) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cap_q == NUM_TAPS) begin
                    ker_d   = w_ker;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ker_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase
        if (w_accept) begin
            state_d = S_FETCH;
            bank_d  = rd_bank;
            addr_d  = rd_base;
            issue_d = '0;
            cap_d   = '0;
        end
    end

    assign ker_out   = ker_q;
    assign ker_valid = valid_q;
    assign idle      = (state_q == S_IDLE);

`ifdef WB_COLLISION_CHK_EN
    logic [ADDR_LEN-1:0] base_q;
    logic                err_q;
    logic [ADDR_LEN-1:0] w_off;
    logic                w_hit;

    // Modular distance from the fetch base covers the wrapped window too.
    assign w_off = wr_addr - base_q;
    assign w_hit = wr_en && (wr_bank == bank_q) &&
                   ((state_q == S_FETCH) || (state_q == S_DRAIN)) &&
                   (int'(w_off) < KTAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (w_accept) begin
                base_q <= rd_base;
            end
            if (w_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_collision = err_q;
`else
    assign err_collision = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_buffer_pp.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_weight_buffer_pp : directed bench for weight_buffer_pp. Rev 1.0           |
// +-----------------------------------------------------------------------------+
module tb_weight_buffer_pp;

    localparam int LANES = 4;
    localparam int KTAPS = 9;
    localparam int ALEN  = 4;
    localparam int WRL   = 16;
    localparam int RDL   = 2;
    localparam int KW    = LANES * 8 * KTAPS;
    localparam int LAT   = KTAPS + RDL + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wr_en;
    logic            wr_bank;
    logic [ALEN-1:0] wr_addr;
    logic [0:0]      wr_sel;
    logic [WRL-1:0]  wr_data;
    logic            rd_start;
    logic            rd_bank;
    logic [ALEN-1:0] rd_base;
    logic [KW-1:0]   ker_out;
    logic            ker_valid;
    logic            ker_ready;
    logic            idle;
    logic            err_collision;

    logic [31:0]     mem_m [0:1][0:15];
    int              n_chk = 0;
    int              n_fail = 0;
    int              lat;
    logic            exp_err;

    always #5 clk = ~clk;

    weight_buffer_pp #(
        .LANES(LANES), .KTAPS(KTAPS), .ADDR_LEN(ALEN), .WR_LEN(WRL), .RD_LAT(RDL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_start(rd_start), .rd_bank(rd_bank), .rd_base(rd_base),
        .ker_out(ker_out), .ker_valid(ker_valid), .ker_ready(ker_ready),
        .idle(idle), .err_collision(err_collision)
    );

    task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input bit b, input int row, input int sel, input logic [15:0] d);
        wr_en = 1'b1; wr_bank = b; wr_addr = ALEN'(row); wr_sel = 1'(sel); wr_data = d;
        mem_m[b][row][sel*16 +: 16] = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic write_row(input bit b, input int row, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        wr(b, row, 0, {b1, b0});
        wr(b, row, 1, {b3, b2});
    endtask

    function automatic logic [KW-1:0] exp_vec(input bit b, input int base);
        logic [KW-1:0] v;
        logic [31:0]   row;
        v = '0;
        for (int k = 0; k < KTAPS; k++) begin
            row = mem_m[b][(base + k) % 16];
            for (int l = 0; l < LANES; l++) begin
                v[(l*KTAPS + k)*8 +: 8] = row[l*8 +: 8];
            end
        end
        return v;
    endfunction

    // Called #1 after an edge; the next edge samples the request.
    task automatic start(input bit b, input int base);
        rd_start = 1'b1; rd_bank = b; rd_base = ALEN'(base);
        @(posedge clk); #1;
        rd_start = 1'b0;
    endtask

    // mode: 0 none, 1 refill bank1, 2 stray rd_start, 3 colliding write
    task automatic wait_valid(input int mode, output int lat_o);
        lat_o = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            rd_start = 1'b0;
            wr_en    = 1'b0;
            if (ker_valid) begin
                lat_o = i;
                break;
            end
            if (mode == 1) begin
                wr_en = 1'b1; wr_bank = 1'b1; wr_addr = ALEN'((i - 1) / 2);
                wr_sel = 1'((i - 1) % 2); wr_data = 16'hA000 + 16'(i);
                mem_m[1][(i - 1) / 2][((i - 1) % 2)*16 +: 16] = wr_data;
            end else if (mode == 2 && i == 3) begin
                rd_start = 1'b1; rd_bank = 1'b0; rd_base = 4'd9;
            end else if (mode == 3 && i == 2) begin
                wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 4'd5; wr_sel = 1'b0;
                wr_data = mem_m[0][5][15:0];
            end
        end
        rd_start = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic handshake(input string tag);
        ker_ready = 1'b1;
        @(posedge clk); #1;
        ker_ready = 1'b0;
        check({tag, "_valid_drop"}, ker_valid, 1'b0);
        check({tag, "_idle"}, idle, 1'b1);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; wr_en = 1'b0; wr_bank = 1'b0; wr_addr = '0; wr_sel = '0; wr_data = '0;
        rd_start = 1'b0; rd_bank = 1'b0; rd_base = '0; ker_ready = 1'b0;
`ifdef WB_COLLISION_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_ker_out", ker_out, '0);
        check("rst_valid", ker_valid, 1'b0);
        check("rst_idle", idle, 1'b1);
        check("rst_err", err_collision, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_ker_out", ker_out, '0);
        check("post_valid", ker_valid, 1'b0);
        check("post_idle", idle, 1'b1);

        for (int r = 0; r < 16; r++) begin
            write_row(1'b0, r, 8'(r), 8'(r + 1), 8'(r + 2), 8'(r + 3));
            write_row(1'b1, r, 8'(8'h80 + r), 8'(8'h90 + r), 8'(8'hB0 + r), 8'(8'hD0 + r));
        end

        // Basic fetch: tap k lane l = 3+k+l
        start(1'b0, 3);
        wait_valid(0, lat);
        check("basic_lat", lat, LAT);
        check("basic_vec", ker_out, exp_vec(1'b0, 3));
        check("basic_t0l0", ker_out[0 +: 8], 8'd3);
        check("basic_t8l3", ker_out[(3*KTAPS + 8)*8 +: 8], 8'd14);
        check("basic_t4l2", ker_out[(2*KTAPS + 4)*8 +: 8], 8'd9);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("hold_valid", ker_valid, 1'b1);
            check("hold_vec", ker_out, exp_vec(1'b0, 3));
        end
        handshake("basic");
        ker_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ker_ready = 1'b0;
        check("idle_ready_valid", ker_valid, 1'b0);
        check("idle_ready_idle", idle, 1'b1);

        // Wrap: rows 12..15 then 0..4
        start(1'b0, 12);
        wait_valid(0, lat);
        check("wrap_lat", lat, LAT);
        check("wrap_vec", ker_out, exp_vec(1'b0, 12));
        check("wrap_t3l2", ker_out[(2*KTAPS + 3)*8 +: 8], 8'd17);
        check("wrap_t4l0", ker_out[(0*KTAPS + 4)*8 +: 8], 8'd0);
        check("wrap_t8l1", ker_out[(1*KTAPS + 8)*8 +: 8], 8'd5);
        handshake("wrap");

        // Ping-pong: refill bank1 while fetching bank0
        start(1'b0, 0);
        wait_valid(1, lat);
        check("pp_lat", lat, LAT);
        check("pp_vec0", ker_out, exp_vec(1'b0, 0));
        check("pp_err", err_collision, 1'b0);
        handshake("pp0");
        start(1'b1, 0);
        wait_valid(0, lat);
        check("pp_lat1", lat, LAT);
        check("pp_vec1", ker_out, exp_vec(1'b1, 0));
        check("pp_new_t0l0", ker_out[0 +: 8], 8'h01);
        check("pp_old_t8l0", ker_out[8*8 +: 8], 8'h88);
        handshake("pp1");

        // rd_start during FETCH is ignored
        start(1'b0, 1);
        wait_valid(2, lat);
        check("ign_lat", lat, LAT);
        check("ign_vec", ker_out, exp_vec(1'b0, 1));
        handshake("ign");
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (ker_valid || !idle) seen = 1'b1;
        end
        check("ign_no_second", seen, 1'b0);

        // Back-to-back: new request in the handshake cycle
        start(1'b0, 2);
        wait_valid(0, lat);
        check("b2b_lat1", lat, LAT);
        check("b2b_vec1", ker_out, exp_vec(1'b0, 2));
        ker_ready = 1'b1; rd_start = 1'b1; rd_bank = 1'b0; rd_base = 4'd7;
        @(posedge clk); #1;
        ker_ready = 1'b0; rd_start = 1'b0;
        check("b2b_drop", ker_valid, 1'b0);
        check("b2b_busy", idle, 1'b0);
        wait_valid(0, lat);
        check("b2b_lat2", lat, LAT);
        check("b2b_vec2", ker_out, exp_vec(1'b0, 7));
        handshake("b2b");

        // Asynchronous reset in the middle of DRAIN
        start(1'b0, 4);
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy", idle, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", ker_valid, 1'b0);
        check("mid_rst_idle", idle, 1'b1);
        check("mid_rst_ker", ker_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("mid_after_valid", ker_valid, 1'b0);
        check("mid_after_idle", idle, 1'b1);

        // Write to bank0 row 5 inside fetch window 3..11
        start(1'b0, 3);
        wait_valid(3, lat);
        check("col_lat", lat, LAT);
        check("col_vec", ker_out, exp_vec(1'b0, 3));
        check("col_err", err_collision, exp_err);
        handshake("col");
        repeat (3) @(posedge clk);
        #1;
        check("col_sticky", err_collision, exp_err);
        rst_n = 1'b0;
        #1;
        check("col_rst", err_collision, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
